// File: rtl/sym_fir_stream.sv
// Symmetric streaming FIR: folds mirrored taps with a pre-adder, then multiplies, sums, rounds and saturates.
// Latency: out_valid rises 4 clk cycles after the edge that accepts a sample; throughput 1 sample/cycle.
// Backpressure: in_ready = 1 only in RUN; a coefficient commit drops it until the pipeline drains and the bank swaps.
//
// Ports: clk/clr (async active-high); coeff_we/coeff_addr/coeff_data write the shadow bank;
// coeff_commit requests shadow->active copy; in_valid/in_ready/in_data sample input;
// out_valid (1-cycle pulse), out_data/out_sat (held between pulses).
module sym_fir_stream #(
    parameter int DATA_WIDTH  = 12,
    parameter int COEFF_WIDTH = 8,
    parameter int TAPS        = 12,
    parameter int OUT_WIDTH   = 16,
    parameter int OUT_SHIFT   = 0,
    localparam int UNIQ       = (TAPS + 1) / 2,
    localparam int AW         = (UNIQ > 1) ? $clog2(UNIQ) : 1,
    localparam int ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + 1 + $clog2(UNIQ)
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          coeff_we,
    input  logic [AW-1:0]                 coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data,
    input  logic                          coeff_commit,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    output logic                          out_valid,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          out_sat
);

    localparam int HALF = TAPS / 2;
    localparam int P_W  = DATA_WIDTH + 1;          // pre-adder result
    localparam int M_W  = P_W + COEFF_WIDTH;       // full-precision product
    localparam int R_W  = ACC_WIDTH + 1;           // headroom for the rounding add
    localparam int C_W  = ((R_W > OUT_WIDTH) ? R_W : OUT_WIDTH) + 1;

    // Half-LSB rounding constant; evaluates to zero when no shift is applied.
    localparam logic signed [R_W-1:0] RND     = R_W'((64'sd1 <<< OUT_SHIFT) >>> 1);
    localparam logic signed [C_W-1:0] SAT_MAX = (C_W'(1) <<< (OUT_WIDTH - 1)) - C_W'(1);
    localparam logic signed [C_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

    state_t                         state_q, state_d;
    logic signed [DATA_WIDTH-1:0]   x_q[TAPS], x_d[TAPS];
    logic signed [P_W-1:0]          p_q[UNIQ], p_d[UNIQ];
    logic signed [M_W-1:0]          m_q[UNIQ], m_d[UNIQ];
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [COEFF_WIDTH-1:0]  shadow_q[UNIQ], shadow_d[UNIQ];
    logic signed [COEFF_WIDTH-1:0]  active_q[UNIQ], active_d[UNIQ];
    logic                           x_vld_q, x_vld_d;
    logic                           p_vld_q, p_vld_d;
    logic                           m_vld_q, m_vld_d;
    logic                           a_vld_q, a_vld_d;
    logic                           out_valid_q, out_valid_d;
    logic signed [OUT_WIDTH-1:0]    out_data_q, out_data_d;
    logic                           out_sat_q, out_sat_d;

    logic                           accept;
    logic signed [R_W-1:0]          r_c;
    logic signed [C_W-1:0]          rx_c;

    assign in_ready  = (state_q == RUN);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        p_d         = p_q;
        m_d         = m_q;
        acc_d       = '0;
        r_c         = '0;
        rx_c        = '0;

        // Valid bits march alongside the data; the delay-line update is stage 0.
        x_vld_d     = accept;
        p_vld_d     = x_vld_q;
        m_vld_d     = p_vld_q;
        a_vld_d     = m_vld_q;
        out_valid_d = a_vld_q;

        if (accept) begin
            x_d[0] = in_data;
            for (int k = 1; k < TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end

        // Pre-add mirrored taps. The odd-length centre tap has no partner and is not doubled.
        for (int k = 0; k < HALF; k++) begin
            p_d[k] = P_W'(x_q[k]) + P_W'(x_q[TAPS-1-k]);
        end
        if (TAPS % 2 == 1) begin
            p_d[UNIQ-1] = P_W'(x_q[UNIQ-1]);
        end

        // The active bank is only read here; the swap waits until nothing upstream of this stage is live.
        for (int k = 0; k < UNIQ; k++) begin
            m_d[k] = M_W'(p_q[k]) * M_W'(active_q[k]);
        end

        for (int k = 0; k < UNIQ; k++) begin
            acc_d = acc_d + ACC_WIDTH'(m_q[k]);
        end

        r_c  = (R_W'(acc_q) + RND) >>> OUT_SHIFT;
        rx_c = C_W'(r_c);
        if (a_vld_q) begin
            if (rx_c > SAT_MAX) begin
                out_data_d = OUT_WIDTH'(SAT_MAX);
                out_sat_d  = 1'b1;
            end else if (rx_c < SAT_MIN) begin
                out_data_d = OUT_WIDTH'(SAT_MIN);
                out_sat_d  = 1'b1;
            end else begin
                out_data_d = OUT_WIDTH'(rx_c);
                out_sat_d  = 1'b0;
            end
        end

        if (coeff_we && (int'(coeff_addr) < UNIQ)) begin
            shadow_d[coeff_addr] = coeff_data;
        end

        case (state_q)
            RUN: begin
                if (coeff_commit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!(x_vld_q || p_vld_q || m_vld_q || a_vld_q)) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                active_d = shadow_q;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= RUN;
            acc_q       <= '0;
            x_vld_q     <= 1'b0;
            p_vld_q     <= 1'b0;
            m_vld_q     <= 1'b0;
            a_vld_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
            for (int k = 0; k < UNIQ; k++) begin
                p_q[k]      <= '0;
                m_q[k]      <= '0;
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            p_q         <= p_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            x_vld_q     <= x_vld_d;
            p_vld_q     <= p_vld_d;
            m_vld_q     <= m_vld_d;
            a_vld_q     <= a_vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_sym_fir_stream.sv
// Bench for sym_fir_stream: three instances (TAPS=12, TAPS=5, TAPS=6 with OUT_SHIFT=2) sharing clk/clr.
// Expected results come from a direct-form FIR model and are queued per instance when a sample is accepted.
// A negedge monitor pops and compares every out_valid, and checks that outputs hold between pulses.
module tb_sym_fir_stream;

    localparam int T[3]  = '{12, 5, 6};
    localparam int SH[3] = '{0, 0, 2};

    logic                clk;
    logic                clr;
    logic                iv[3], ordy[3], cwe[3], ccom[3], ov[3], osat[3];
    logic signed [11:0]  id[3];
    logic [2:0]          caddr[3];
    logic signed [7:0]   cdata[3];
    logic signed [15:0]  od[3];

    typedef struct {
        int data;
        bit sat;
        int cyc;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int   cap1[$], cap2[$];
    int   hist[3][12];
    int   act[3][6];
    int   shd[3][6];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    logic signed [15:0] last_od[3];
    logic               last_sat[3];

    sym_fir_stream u_d12 (
        .clk(clk), .clr(clr), .coeff_we(cwe[0]), .coeff_addr(caddr[0]), .coeff_data(cdata[0]),
        .coeff_commit(ccom[0]), .in_valid(iv[0]), .in_ready(ordy[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_sat(osat[0]));

    sym_fir_stream #(.TAPS(5)) u_d5 (
        .clk(clk), .clr(clr), .coeff_we(cwe[1]), .coeff_addr(caddr[1][1:0]), .coeff_data(cdata[1]),
        .coeff_commit(ccom[1]), .in_valid(iv[1]), .in_ready(ordy[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_sat(osat[1]));

    sym_fir_stream #(.TAPS(6), .OUT_SHIFT(2)) u_d6 (
        .clk(clk), .clr(clr), .coeff_we(cwe[2]), .coeff_addr(caddr[2][1:0]), .coeff_data(cdata[2]),
        .coeff_commit(ccom[2]), .in_valid(iv[2]), .in_ready(ordy[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_data(od[2]), .out_sat(osat[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void qpush(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    // Direct-form reference: y = sum h[k]*x[k] with h mirrored from the unique coefficients.
    function automatic exp_t model_step(input int i, input int v);
        exp_t e;
        int acc, r, u, idx;
        for (int k = T[i] - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = v;
        u = (T[i] + 1) / 2;
        acc = 0;
        for (int k = 0; k < T[i]; k++) begin
            idx = (k < u) ? k : T[i] - 1 - k;
            acc += hist[i][k] * act[i][idx];
        end
        r = (SH[i] > 0) ? ((acc + (1 << (SH[i] - 1))) >>> SH[i]) : acc;
        e.sat = 1'b0;
        if (r > 32767) begin
            r = 32767;
            e.sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            e.sat = 1'b1;
        end
        e.data = r;
        e.cyc  = cyc;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (clr) begin
            q0.delete();
            q1.delete();
            q2.delete();
            for (int i = 0; i < 3; i++) begin
                last_od[i]  = '0;
                last_sat[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i] === 1'b1) begin
                    n_chk++;
                    if (qsize(i) == 0) begin
                        $display("FAIL unexpected_out inst%0d: out_valid with data %0d, required no output", i, od[i]);
                    end else begin
                        e = qpop(i);
                        if (od[i] !== 16'(e.data) || osat[i] !== e.sat)
                            $display("FAIL result inst%0d: got data %0d sat %0b, required data %0d sat %0b",
                                     i, od[i], osat[i], e.data, e.sat);
                        else n_pass++;
                        n_chk++;
                        if (cyc !== e.cyc + 5)
                            $display("FAIL latency inst%0d: output at cycle %0d, required %0d", i, cyc, e.cyc + 5);
                        else n_pass++;
                    end
                    if (i == 1) cap1.push_back(int'(od[i]));
                    if (i == 2) cap2.push_back(int'(od[i]));
                    last_od[i]  = od[i];
                    last_sat[i] = osat[i];
                end else begin
                    n_chk++;
                    if (od[i] !== last_od[i] || osat[i] !== last_sat[i])
                        $display("FAIL hold inst%0d: got %0d/%0b while idle, required %0d/%0b",
                                 i, od[i], osat[i], last_od[i], last_sat[i]);
                    else n_pass++;
                end
            end
        end
    end

    task automatic cycle_in(input int i, input bit vld, input int v);
        @(negedge clk);
        iv[i] = vld;
        id[i] = 12'(v);
        if (vld && ordy[i]) qpush(i, model_step(i, v));
    endtask

    task automatic wr_coef(input int i, input int a, input int v);
        @(negedge clk);
        cwe[i]   = 1'b1;
        caddr[i] = 3'(a);
        cdata[i] = 8'(v);
        if (a < (T[i] + 1) / 2) shd[i][a] = v;
        @(negedge clk);
        cwe[i] = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((qsize(0) + qsize(1) + qsize(2)) != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        n_chk++;
        if ((qsize(0) + qsize(1) + qsize(2)) != 0)
            $display("FAIL drain: %0d results still outstanding, required 0", qsize(0) + qsize(1) + qsize(2));
        else n_pass++;
    endtask

    // Commit on an idle pipeline, holding the strobe one extra cycle so it is also seen in DRAIN.
    task automatic do_commit(input int i, input int exp_low);
        int low;
        @(negedge clk);
        ccom[i] = 1'b1;
        n_chk++;
        if (ordy[i] !== 1'b1) $display("FAIL commit_from_run inst%0d: in_ready %0b, required 1", i, ordy[i]);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (ordy[i] !== 1'b0) $display("FAIL ready_drop inst%0d: in_ready %0b, required 0", i, ordy[i]);
        else n_pass++;
        low = 1;
        while (low < 40) begin
            @(negedge clk);
            ccom[i] = 1'b0;
            if (ordy[i] === 1'b1) break;
            low++;
        end
        n_chk++;
        if (low !== exp_low) $display("FAIL commit_low inst%0d: in_ready low %0d cycles, required %0d", i, low, exp_low);
        else n_pass++;
        for (int k = 0; k < 6; k++) act[i][k] = shd[i][k];
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (ordy[i] !== 1'b1) $display("FAIL reset_ready inst%0d: got %0b, required 1", i, ordy[i]); else n_pass++;
            n_chk++;
            if (ov[i] !== 1'b0) $display("FAIL reset_valid inst%0d: got %0b, required 0", i, ov[i]); else n_pass++;
            n_chk++;
            if (od[i] !== 16'sd0) $display("FAIL reset_data inst%0d: got %0d, required 0", i, od[i]); else n_pass++;
            n_chk++;
            if (osat[i] !== 1'b0) $display("FAIL reset_sat inst%0d: got %0b, required 0", i, osat[i]); else n_pass++;
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_impulse_odd();
        int exp_o[6] = '{1, 2, 3, 2, 1, 0};
        wr_coef(1, 0, 1);
        wr_coef(1, 1, 2);
        wr_coef(1, 2, 3);
        wr_coef(1, 3, 99);
        do_commit(1, 2);
        cap1.delete();
        cycle_in(1, 1, 1);
        repeat (5) cycle_in(1, 1, 0);
        cycle_in(1, 0, 0);
        drain();
        n_chk++;
        if (cap1.size() != 6) $display("FAIL odd_count: got %0d outputs, required 6", cap1.size()); else n_pass++;
        for (int k = 0; k < 6 && k < cap1.size(); k++) begin
            n_chk++;
            if (cap1[k] !== exp_o[k]) $display("FAIL odd_impulse[%0d]: got %0d, required %0d", k, cap1[k], exp_o[k]);
            else n_pass++;
        end
    endtask

    task automatic test_impulse_even_shift();
        int exp_o[18] = '{1, 2, 3, 3, 2, 1, 2, 0, 0, 0, 0, 2, -1, 0, 0, 0, 0, -1};
        wr_coef(2, 0, 1);
        wr_coef(2, 1, 2);
        wr_coef(2, 2, 3);
        do_commit(2, 2);
        cap2.delete();
        cycle_in(2, 1, 4);
        repeat (5) cycle_in(2, 1, 0);
        cycle_in(2, 0, 0);
        drain();
        wr_coef(2, 0, 6);
        wr_coef(2, 1, 0);
        wr_coef(2, 2, 0);
        do_commit(2, 2);
        cycle_in(2, 1, 1);
        repeat (5) cycle_in(2, 1, 0);
        cycle_in(2, 1, -1);
        repeat (5) cycle_in(2, 1, 0);
        cycle_in(2, 0, 0);
        drain();
        n_chk++;
        if (cap2.size() != 18) $display("FAIL even_count: got %0d outputs, required 18", cap2.size()); else n_pass++;
        for (int k = 0; k < 18 && k < cap2.size(); k++) begin
            n_chk++;
            if (cap2[k] !== exp_o[k]) $display("FAIL even_shift[%0d]: got %0d, required %0d", k, cap2[k], exp_o[k]);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        for (int a = 0; a < 6; a++) wr_coef(0, a, 127);
        do_commit(0, 2);
        repeat (12) cycle_in(0, 1, 2047);
        cycle_in(0, 0, 0);
        drain();
        n_chk++;
        if (od[0] !== 16'sd32767 || osat[0] !== 1'b1)
            $display("FAIL sat_pos: got %0d/%0b, required 32767/1", od[0], osat[0]);
        else n_pass++;
        repeat (12) cycle_in(0, 1, -2048);
        cycle_in(0, 0, 0);
        drain();
        n_chk++;
        if (od[0] !== -16'sd32768 || osat[0] !== 1'b1)
            $display("FAIL sat_neg: got %0d/%0b, required -32768/1", od[0], osat[0]);
        else n_pass++;
        repeat (12) cycle_in(0, 1, 0);
        cycle_in(0, 0, 0);
        drain();
        n_chk++;
        if (od[0] !== 16'sd0 || osat[0] !== 1'b0)
            $display("FAIL sat_clear: got %0d/%0b, required 0/0", od[0], osat[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 6; a++) wr_coef(0, a, int'($urandom_range(0, 255)) - 128);
        do_commit(0, 2);
        repeat (20) cycle_in(0, 1, int'($urandom_range(0, 4095)) - 2048);
        repeat (60) cycle_in(0, ($urandom_range(0, 9) < 7), int'($urandom_range(0, 4095)) - 2048);
        cycle_in(0, 0, 0);
        drain();
    endtask

    task automatic test_commit_stream();
        bit pending = 1'b0;
        bit com;
        int low = 0;
        wr_coef(1, 0, 4);
        wr_coef(1, 1, 5);
        wr_coef(1, 2, 6);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            com     = (n == 4);
            ccom[1] = com;
            iv[1]   = 1'b1;
            id[1]   = 12'(int'($urandom_range(0, 4095)) - 2048);
            if (pending) begin
                if (ordy[1] !== 1'b1) low++;
                else begin
                    for (int k = 0; k < 6; k++) act[1][k] = shd[1][k];
                    pending = 1'b0;
                    n_chk++;
                    if (low !== 6) $display("FAIL stream_commit_low: in_ready low %0d cycles, required 6", low);
                    else n_pass++;
                end
            end
            if (ordy[1] === 1'b1) qpush(1, model_step(1, int'(id[1])));
            if (com) begin
                pending = 1'b1;
                low = 0;
            end
        end
        ccom[1] = 1'b0;
        cycle_in(1, 0, 0);
        drain();
        n_chk++;
        if (pending) $display("FAIL stream_commit_swap: in_ready still low after %0d cycles, required return", low);
        else n_pass++;
    endtask

    task automatic test_clr_in_flight();
        repeat (3) cycle_in(0, 1, 500);
        @(negedge clk);
        clr   = 1'b1;
        iv[0] = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 12; k++) begin
                hist[i][k] = 0;
                if (k < 6) begin
                    act[i][k] = 0;
                    shd[i][k] = 0;
                end
            end
        #1;
        n_chk++;
        if (ov[0] !== 1'b0 || od[0] !== 16'sd0 || osat[0] !== 1'b0)
            $display("FAIL clr_async: got valid %0b data %0d sat %0b, required 0/0/0", ov[0], od[0], osat[0]);
        else n_pass++;
        @(negedge clk);
        clr = 1'b0;
        repeat (8) cycle_in(0, 0, 0);
        n_chk++;
        if (ordy[0] !== 1'b1) $display("FAIL clr_ready: got %0b, required 1", ordy[0]); else n_pass++;
        cycle_in(0, 1, 1000);
        cycle_in(0, 0, 0);
        drain();
        n_chk++;
        if (od[0] !== 16'sd0) $display("FAIL clr_coeffs: got %0d, required 0", od[0]); else n_pass++;
    endtask

    initial begin
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; id[i] = '0; cwe[i] = 1'b0; caddr[i] = '0; cdata[i] = '0; ccom[i] = 1'b0;
            last_od[i] = '0; last_sat[i] = 1'b0;
            for (int k = 0; k < 12; k++) hist[i][k] = 0;
            for (int k = 0; k < 6; k++) begin
                act[i][k] = 0;
                shd[i][k] = 0;
            end
        end
        test_reset();
        test_impulse_odd();
        test_impulse_even_shift();
        test_saturation();
        test_back_to_back();
        test_commit_stream();
        test_clr_in_flight();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
